chan_step_sched: RTL and testbench
==================================

# chan_step_sched

Timestep scheduler for the channel-interpolation emulation model. Up to N_REQ requesters each register a time-to-next-event, such as a TX symbol edge or an RX sample instant. Every cycle, the block issues a step equal to the smallest outstanding time, clamped to DT_MAX, on the model's `dt` input. It advances emulated time and pulses a grant to each requester whose event time has been reached.

## Interface
- N_REQ, 4: number of requester slots.
- DT_W, 16: width of dt values, unsigned integer LSBs of the model's dt fixed-point format.
- DT_MAX, 16'd1000: free-run step used when no slot is pending, and the upper clamp on every step.
- TIME_W, 32: emulated-time counter width.

Ports (clock and reset first):
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-slot request strobe.
- req_dt  in  N_REQ×DT_W  requested time to event, relative to the current emulated time.
- req_ready  out  N_REQ  slot free; accept occurs when valid and ready are both 1 at a clk edge.
- grant  out  N_REQ  one-cycle pulse when the slot's event is reached.
- stall  in  1  freezes stepping while high.
- flush  in  1  synchronous clear of all pending slots.
- dt_out  out  DT_W  step applied to the model this cycle.
- step_valid  out  1  dt_out is a real step.
- emu_time  out  TIME_W  accumulated emulated time.

## Operation
- Per-slot state: pending bit and rem[i] (DT_W bits). req_ready[i] is the combinational inverse of pending[i], forced to 0 while rst is asserted.
- On accept, rem[i] takes req_dt[i] and pending[i] is set. A req_dt of 0 is stored as 1; the model cannot take zero-length steps.
- Step value: step = min(DT_MAX, rem[i] over all pending i). If no slot is pending, step = DT_MAX. The step is computed from the registered rem values only, so a slot accepted in cycle t first affects the step in cycle t+1.
- FSM states:
  - RUN: on each edge, dt_out is loaded with the step and step_valid is set to 1. rem[i] is decremented by the step for each pending slot. Any slot reaching 0 clears its pending bit and pulses grant[i]. emu_time += step, wrapping modulo 2^TIME_W.
  - HOLD: entered from RUN when stall=1 at an edge. dt_out=0, step_valid=0, rem and emu_time are unchanged, no grants. Returns to RUN when stall=0.
  - FLUSH: entered when flush=1, from either state. All pending bits clear, no grants, dt_out=0, step_valid=0. Lasts exactly one cycle, then goes to HOLD if stall=1, otherwise RUN.
- Priority is flush > stall > run.
- Simultaneous grants are allowed. Every slot whose rem equals the step is granted on the same edge; there is no tie-break.
- A slot cannot be granted and re-accepted on the same edge. A re-accept requires req_ready, which rises in the cycle after the grant.
- Accepts are taken in every state, including FLUSH. An accept on the flush edge survives the flush.

## Timing
- Reset values: dt_out=0, step_valid=0, grant=0, emu_time=0, all rem=0, all pending=0, FSM state RUN.
- Accept-to-grant latency for req_dt=d, with no stall and no other pending slots:
  - Requires d ≤ DT_MAX.
  - Accept at edge k; grant is high in the cycle after edge k+1.
  - dt_out=d in that same cycle.
- For d > DT_MAX, the slot is stepped by DT_MAX once per cycle, and the grant arrives ceil(d/DT_MAX) steps after the accept.
- dt_out and grant are registered and aligned. A grant always coincides with the step that reaches the event.
- Stall raised at edge k: the cycle after edge k shows step_valid=0. Release at edge j: the step resumes in the cycle after edge j.
- Reset asserted mid-operation: all state clears immediately and asynchronously. The first step after deassertion is DT_MAX.

## Configuration
- CHAN_SCHED_STATS_EN defined: adds the following outputs, both clearing on reset.
  - step_count, TIME_W bits: counts edges with step_valid=1.
  - clamp_count, TIME_W bits: counts steps where step==DT_MAX while at least one slot is pending.
- CHAN_SCHED_STATS_EN undefined: these ports and their registers are absent. All other behaviour is identical.

## Structure
- Package chan_sched_pkg contains:
  - DT_W and TIME_W defaults.
  - typedef dt_t (logic [DT_W-1:0]) and typedef time_t.
  - enum sched_state_t {RUN, HOLD, FLUSH}.
- Sub-module chan_sched_min: combinational min-reduction tree over N_REQ masked rem values plus DT_MAX. It outputs the step value and a one-hot "hits" vector (rem==step and pending), which drives the grants.

## Test plan
- Idle after reset: no requests for 5 cycles → dt_out=1000 and step_valid=1 every cycle; emu_time=5000.
- Single request: slot 0 accepts req_dt=300 → the next step has dt_out=300 with grant[0] in the same cycle; req_ready[0] returns to 1 in the following cycle.
- Tie and ordering: slots 1 and 2 accept 200, slot 3 accepts 500 on the same edge → step 200 with grant[1] and grant[2] together, then step 300 with grant[3].
- Clamp: slot 0 accepts 2500 → steps of 1000, 1000, 500, with grant[0] only on the 500 step.
- Stall and flush:
  - Slot 0 pending at 400, stall for 3 cycles → step_valid=0 for 3 cycles, then step 400 with the grant.
  - Flush with slot 0 pending → no grant, and the next step is 1000.
- Reset mid-run with 2 slots pending → all outputs read 0 while rst=0; after release, req_ready is all 1 and the first step is 1000.

Source files
------------

// File: rtl/chan_sched_pkg.sv
// Shared types and widths for the channel-model timestep scheduler.
package chan_sched_pkg;
  localparam int DT_W   = 16;
  localparam int TIME_W = 32;

  typedef logic [DT_W-1:0]   dt_t;
  typedef logic [TIME_W-1:0] time_t;

  typedef enum logic [1:0] {RUN, HOLD, FLUSH} sched_state_t;
endpackage

// File: rtl/chan_sched_min.sv
// Min-reduction over the pending slots' remaining times, seeded with DT_MAX.
// Also flags every pending slot whose remaining time equals the chosen step.
module chan_sched_min
  import chan_sched_pkg::*;
#(
  parameter int  N_REQ  = 4,
  parameter dt_t DT_MAX = 16'd1000
) (
  input  logic [N_REQ-1:0]           i_pending,
  input  logic [N_REQ-1:0][DT_W-1:0] i_rem,
  output dt_t                        o_step,
  output logic [N_REQ-1:0]           o_hits
);

  always_comb begin
    o_step = DT_MAX;
    for (int i = 0; i < N_REQ; i++) begin
      if (i_pending[i] && (i_rem[i] < o_step)) o_step = i_rem[i];
    end
    o_hits = '0;
    for (int i = 0; i < N_REQ; i++) begin
      o_hits[i] = i_pending[i] && (i_rem[i] == o_step);
    end
  end

endmodule

// File: rtl/chan_step_sched.sv
// Timestep scheduler: issues min(DT_MAX, pending remaining times) each cycle.
// Optional statistics counters are enabled by defining CHAN_SCHED_STATS_EN.
module chan_step_sched
  import chan_sched_pkg::*;
#(
  parameter int  N_REQ  = 4,
  parameter dt_t DT_MAX = 16'd1000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0][DT_W-1:0] req_dt,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           grant,
  input  logic                       stall,
  input  logic                       flush,
  output dt_t                        dt_out,
  output logic                       step_valid,
  output time_t                      emu_time
`ifdef CHAN_SCHED_STATS_EN
  ,
  output time_t                      step_count,
  output time_t                      clamp_count
`endif
);

  sched_state_t              r_state;
  sched_state_t              w_next;
  logic [N_REQ-1:0]          r_pending;
  logic [N_REQ-1:0][DT_W-1:0] r_rem;
  dt_t                       w_step;
  logic [N_REQ-1:0]          w_hits;
  logic [N_REQ-1:0]          w_accept;

  assign req_ready = rst ? ~r_pending : '0;
  assign w_accept  = req_valid & req_ready;

  chan_sched_min #(
    .N_REQ  (N_REQ),
    .DT_MAX (DT_MAX)
  ) u_min (
    .i_pending (r_pending),
    .i_rem     (r_rem),
    .o_step    (w_step),
    .o_hits    (w_hits)
  );

  // Flush beats stall beats run, from every state.
  always_comb begin
    w_next = RUN;
    case (r_state)
      RUN, HOLD, FLUSH: w_next = stall ? HOLD : RUN;
      default:          w_next = RUN;
    endcase
    if (flush) w_next = FLUSH;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= RUN;
      r_pending  <= '0;
      r_rem      <= '0;
      dt_out     <= '0;
      step_valid <= 1'b0;
      grant      <= '0;
      emu_time   <= '0;
    end else begin
      r_state <= w_next;
      case (w_next)
        RUN: begin
          dt_out     <= w_step;
          step_valid <= 1'b1;
          grant      <= w_hits;
          emu_time   <= emu_time + TIME_W'(w_step);
          for (int i = 0; i < N_REQ; i++) begin
            if (r_pending[i]) r_rem[i] <= r_rem[i] - w_step;
          end
          r_pending <= r_pending & ~w_hits;
        end
        FLUSH: begin
          dt_out     <= '0;
          step_valid <= 1'b0;
          grant      <= '0;
          r_pending  <= '0;
        end
        default: begin
          dt_out     <= '0;
          step_valid <= 1'b0;
          grant      <= '0;
        end
      endcase
      // Accepts land last so they survive a flush; zero-length requests become 1.
      for (int i = 0; i < N_REQ; i++) begin
        if (w_accept[i]) begin
          r_rem[i]     <= (req_dt[i] == '0) ? DT_W'(1) : req_dt[i];
          r_pending[i] <= 1'b1;
        end
      end
    end
  end

`ifdef CHAN_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_count  <= '0;
      clamp_count <= '0;
    end else if (w_next == RUN) begin
      step_count <= step_count + 1'b1;
      if ((w_step == DT_MAX) && (|r_pending)) clamp_count <= clamp_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_chan_step_sched.sv
// Directed bench for chan_step_sched with hand-computed expected steps and grants.
module tb_chan_step_sched;
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [3:0]        req_valid = '0;
  logic [3:0][15:0]  req_dt = '0;
  logic [3:0]        req_ready;
  logic [3:0]        grant;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic [15:0]       dt_out;
  logic              step_valid;
  logic [31:0]       emu_time;
`ifdef CHAN_SCHED_STATS_EN
  logic [31:0]       step_count;
  logic [31:0]       clamp_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_emu = 0;

  chan_step_sched dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_dt     (req_dt),
    .req_ready  (req_ready),
    .grant      (grant),
    .stall      (stall),
    .flush      (flush),
    .dt_out     (dt_out),
    .step_valid (step_valid),
    .emu_time   (emu_time)
`ifdef CHAN_SCHED_STATS_EN
    ,
    .step_count (step_count),
    .clamp_count(clamp_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One running edge: expected step value and grant vector.
  task automatic run_step(input string tag, input logic [15:0] dt, input logic [3:0] g);
    tick();
    exp_emu = exp_emu + 32'(dt);
    chk({tag, "_dt"}, 32'(dt_out), 32'(dt));
    chk({tag, "_sv"}, 32'(step_valid), 32'd1);
    chk({tag, "_gnt"}, 32'(grant), 32'(g));
    chk({tag, "_emu"}, emu_time, exp_emu);
  endtask

  task automatic hold_step(input string tag);
    tick();
    chk({tag, "_dt"}, 32'(dt_out), 32'd0);
    chk({tag, "_sv"}, 32'(step_valid), 32'd0);
    chk({tag, "_gnt"}, 32'(grant), 32'd0);
    chk({tag, "_emu"}, emu_time, exp_emu);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_dt", 32'(dt_out), 32'd0);
    chk("rst_sv", 32'(step_valid), 32'd0);
    chk("rst_gnt", 32'(grant), 32'd0);
    chk("rst_emu", emu_time, 32'd0);
    chk("rst_rdy", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_rdy", 32'(req_ready), 32'hF);

    // Idle free-run
    for (int i = 0; i < 5; i++) run_step("idle", 16'd1000, 4'b0000);
    chk("idle_emu5000", emu_time, 32'd5000);

    // Single request
    req_valid = 4'b0001; req_dt[0] = 16'd300;
    run_step("s_acc", 16'd1000, 4'b0000);
    chk("s_rdy_busy", 32'(req_ready), 32'hE);
    req_valid = '0;
    run_step("s_grant", 16'd300, 4'b0001);
    chk("s_rdy_back", 32'(req_ready), 32'hF);
    run_step("s_after", 16'd1000, 4'b0000);

    // Tie and ordering
    req_valid = 4'b1110; req_dt[1] = 16'd200; req_dt[2] = 16'd200; req_dt[3] = 16'd500;
    run_step("t_acc", 16'd1000, 4'b0000);
    req_valid = '0;
    run_step("t_tie", 16'd200, 4'b0110);
    run_step("t_last", 16'd300, 4'b1000);
    run_step("t_idle", 16'd1000, 4'b0000);

    // Clamp
    req_valid = 4'b0001; req_dt[0] = 16'd2500;
    run_step("c_acc", 16'd1000, 4'b0000);
    req_valid = '0;
    run_step("c_1", 16'd1000, 4'b0000);
    run_step("c_2", 16'd1000, 4'b0000);
    run_step("c_3", 16'd500, 4'b0001);

    // Zero request is stored as one
    req_valid = 4'b0001; req_dt[0] = 16'd0;
    run_step("z_acc", 16'd1000, 4'b0000);
    req_valid = '0;
    run_step("z_grant", 16'd1, 4'b0001);

    // Stall
    req_valid = 4'b0001; req_dt[0] = 16'd400;
    run_step("st_acc", 16'd1000, 4'b0000);
    req_valid = '0;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) hold_step("st_hold");
    stall = 1'b0;
    run_step("st_grant", 16'd400, 4'b0001);

    // Flush
    req_valid = 4'b0001; req_dt[0] = 16'd700;
    run_step("f_acc", 16'd1000, 4'b0000);
    req_valid = '0;
    flush = 1'b1;
    hold_step("f_flush");
    flush = 1'b0;
    chk("f_rdy", 32'(req_ready), 32'hF);
    run_step("f_next", 16'd1000, 4'b0000);

    // Accept on the flush edge survives
    flush = 1'b1; req_valid = 4'b0100; req_dt[2] = 16'd50;
    hold_step("fa_flush");
    flush = 1'b0; req_valid = '0;
    chk("fa_rdy", 32'(req_ready), 32'hB);
    run_step("fa_grant", 16'd50, 4'b0100);

    // Reset mid-run
    req_valid = 4'b0011; req_dt[0] = 16'd3000; req_dt[1] = 16'd4000;
    run_step("r_acc", 16'd1000, 4'b0000);
    req_valid = '0;
    run_step("r_run", 16'd1000, 4'b0000);
    rst = 1'b0;
    #1;
    chk("r_dt", 32'(dt_out), 32'd0);
    chk("r_sv", 32'(step_valid), 32'd0);
    chk("r_gnt", 32'(grant), 32'd0);
    chk("r_emu", emu_time, 32'd0);
    chk("r_rdy", 32'(req_ready), 32'd0);
    exp_emu = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("r_rel_rdy", 32'(req_ready), 32'hF);
    run_step("r_first", 16'd1000, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
